multicycle_control: RTL and testbench

- Control FSM for the multicycle RV32I datapath; the issuing end of the ALU's alu_control/zero interface.
- Decodes op/funct fields from the instruction register and sequences fetch/decode/execute/memory/writeback states.
- Drives datapath mux selects, write enables and the 4-bit alu_control, and consumes the ALU zero flag for beq.
- Supported instructions: lw, sw, R-type add/sub/and/or, I-type addi/andi/ori, beq, jal.

---
 rtl/multicycle_control_if.sv | 32 +++
 rtl/multicycle_control.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle for the multicycle RV32I core: instruction fields
// and ALU zero flow into the controller, selects and enables flow out.
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [3:0] alu_control;
  logic       illegal_instr;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr, state
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects, write enables and the ALU function code.
module multicycle_control (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_if.master        bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  state_t state_q, state_d;
  state_t out_state;
  logic   legal;
  logic [3:0] alu_func;

  logic       pc_write_d, adr_src_d, mem_write_d, ir_write_d, reg_write_d, illegal_d;
  logic [1:0] result_src_d, alu_src_a_d, alu_src_b_d, imm_src_d;
  logic [3:0] alu_control_d;

  always_comb begin
    legal = 1'b0;
    case (bus.op)
      OP_LW, OP_SW: legal = (bus.funct3 == 3'b010);
      OP_R:         legal = (bus.funct3 == 3'b000) ||
                            (!bus.funct7b5 && (bus.funct3 == 3'b110 || bus.funct3 == 3'b111));
      OP_I:         legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b110) ||
                            (bus.funct3 == 3'b111);
      OP_BEQ:       legal = (bus.funct3 == 3'b000);
      OP_JAL:       legal = 1'b1;
      default:      legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (legal) begin
          case (bus.op)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_R:         state_d = EXECUTER;
            OP_I:         state_d = EXECUTEI;
            OP_BEQ:       state_d = BEQ;
            OP_JAL:       state_d = JAL;
            default:      state_d = FETCH;
          endcase
        end
      end
      MEMADR:   state_d = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // instr[30] only selects SUB for R-type; addi must ignore it.
  always_comb begin
    alu_func = ALU_ADD;
    case (bus.funct3)
      3'b000:  alu_func = (state_q == EXECUTER && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_func = ALU_AND;
      3'b110:  alu_func = ALU_OR;
      default: alu_func = ALU_ADD;
    endcase
  end

  always_comb begin
    imm_src_d = 2'b00;
    case (bus.op)
      OP_SW:   imm_src_d = 2'b01;
      OP_BEQ:  imm_src_d = 2'b10;
      OP_JAL:  imm_src_d = 2'b11;
      default: imm_src_d = 2'b00;
    endcase
  end

  // Under reset every output takes its FETCH value, then the enables are masked.
  always_comb begin
    out_state     = rst ? FETCH : state_q;
    pc_write_d    = 1'b0;
    adr_src_d     = 1'b0;
    mem_write_d   = 1'b0;
    ir_write_d    = 1'b0;
    reg_write_d   = 1'b0;
    illegal_d     = 1'b0;
    result_src_d  = 2'b00;
    alu_src_a_d   = 2'b00;
    alu_src_b_d   = 2'b00;
    alu_control_d = ALU_ADD;
    case (out_state)
      FETCH: begin
        ir_write_d   = 1'b1;
        pc_write_d   = 1'b1;
        alu_src_b_d  = 2'b10;
        result_src_d = 2'b10;
      end
      DECODE: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b01;
        illegal_d   = !legal;
      end
      MEMADR: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
      end
      MEMREAD:  adr_src_d = 1'b1;
      MEMWB: begin
        result_src_d = 2'b01;
        reg_write_d  = 1'b1;
      end
      MEMWRITE: begin
        adr_src_d   = 1'b1;
        mem_write_d = 1'b1;
      end
      EXECUTER: begin
        alu_src_a_d   = 2'b10;
        alu_control_d = alu_func;
      end
      EXECUTEI: begin
        alu_src_a_d   = 2'b10;
        alu_src_b_d   = 2'b01;
        alu_control_d = alu_func;
      end
      ALUWB:    reg_write_d = 1'b1;
      BEQ: begin
        alu_src_a_d   = 2'b10;
        alu_control_d = ALU_SUB;
        pc_write_d    = bus.zero;
      end
      JAL: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b10;
        pc_write_d  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write_d  = 1'b0;
      ir_write_d  = 1'b0;
      mem_write_d = 1'b0;
      reg_write_d = 1'b0;
      illegal_d   = 1'b0;
    end
  end

  assign bus.pc_write      = pc_write_d;
  assign bus.adr_src       = adr_src_d;
  assign bus.mem_write     = mem_write_d;
  assign bus.ir_write      = ir_write_d;
  assign bus.reg_write     = reg_write_d;
  assign bus.result_src    = result_src_d;
  assign bus.alu_src_a     = alu_src_a_d;
  assign bus.alu_src_b     = alu_src_b_d;
  assign bus.imm_src       = imm_src_d;
  assign bus.alu_control   = alu_control_d;
  assign bus.illegal_instr = illegal_d;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle vector bench for multicycle_control plus per-instruction
// latency sequences.
module tb_multicycle_control;
  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] ILL = 7'b1110011;

  // exp = {state, pc_write, adr_src, mem_write, ir_write, reg_write,
  //        result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr}
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [21:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic [3:0] st,
                     input logic [4:0] we, input logic [1:0] res, input logic [1:0] sa,
                     input logic [1:0] sb, input logic [1:0] im, input logic [3:0] alu,
                     input logic ill);
    vec_t v;
    v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z;
    v.exp = {st, we, res, sa, sb, im, alu, ill};
    vecs.push_back(v);
  endtask

  function automatic logic [21:0] observed();
    return {bus.state, bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
            bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b,
            bus.imm_src, bus.alu_control, bus.illegal_instr};
  endfunction

  initial begin
    logic [6:0] lat_op [7];
    logic [2:0] lat_f3 [7];
    int         lat_n  [7];
    int         n;
    logic [21:0] got;

    bus.op = R; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0;

    // reset with R-type op on the bus
    add(1, R, 3'd0, 0, 0, 4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 0);
    add(1, R, 3'd0, 0, 0, 4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 0);
    // sub
    add(0, R, 3'd0, 1, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 0);
    add(0, R, 3'd0, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 0);
    add(0, R, 3'd0, 1, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 4'h1, 0);
    add(0, R, 3'd0, 1, 0, 4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0);
    // and
    add(0, R, 3'd7, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 0);
    add(0, R, 3'd7, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 0);
    add(0, R, 3'd7, 0, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 4'h2, 0);
    add(0, R, 3'd7, 0, 0, 4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0);
    // or
    add(0, R, 3'd6, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 0);
    add(0, R, 3'd6, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 0);
    add(0, R, 3'd6, 0, 0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 4'h3, 0);
    add(0, R, 3'd6, 0, 0, 4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0);
    // addi with instr[30]=1 still adds
    add(0, I, 3'd0, 1, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 0);
    add(0, I, 3'd0, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 0);
    add(0, I, 3'd0, 1, 0, 4'd7, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 4'h0, 0);
    add(0, I, 3'd0, 1, 0, 4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0);
    // andi
    add(0, I, 3'd7, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 0);
    add(0, I, 3'd7, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 0);
    add(0, I, 3'd7, 0, 0, 4'd7, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 4'h2, 0);
    add(0, I, 3'd7, 0, 0, 4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0);
    // lw
    add(0, LW, 3'd2, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 0);
    add(0, LW, 3'd2, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 0);
    add(0, LW, 3'd2, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 4'h0, 0);
    add(0, LW, 3'd2, 0, 0, 4'd3, 5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0);
    add(0, LW, 3'd2, 0, 0, 4'd4, 5'b00001, 2'b01, 2'b00, 2'b00, 2'b00, 4'h0, 0);
    // sw
    add(0, SW, 3'd2, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b01, 4'h0, 0);
    add(0, SW, 3'd2, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b01, 4'h0, 0);
    add(0, SW, 3'd2, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 4'h0, 0);
    add(0, SW, 3'd2, 0, 0, 4'd5, 5'b01100, 2'b00, 2'b00, 2'b00, 2'b01, 4'h0, 0);
    // beq taken; zero=1 outside BEQ has no effect
    add(0, BQ, 3'd0, 0, 1, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 4'h0, 0);
    add(0, BQ, 3'd0, 0, 1, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 4'h0, 0);
    add(0, BQ, 3'd0, 0, 1, 4'd9, 5'b10000, 2'b00, 2'b10, 2'b00, 2'b10, 4'h1, 0);
    // beq not taken
    add(0, BQ, 3'd0, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 4'h0, 0);
    add(0, BQ, 3'd0, 0, 1, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 4'h0, 0);
    add(0, BQ, 3'd0, 0, 0, 4'd9, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 4'h1, 0);
    // jal
    add(0, JL, 3'd0, 0, 1, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b11, 4'h0, 0);
    add(0, JL, 3'd0, 0, 1, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b11, 4'h0, 0);
    add(0, JL, 3'd0, 0, 0, 4'd10, 5'b10000, 2'b00, 2'b01, 2'b10, 2'b11, 4'h0, 0);
    add(0, JL, 3'd0, 0, 1, 4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b11, 4'h0, 0);
    // illegal opcode, then illegal funct combinations
    add(0, ILL, 3'd0, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 0);
    add(0, ILL, 3'd0, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 1);
    add(0, R, 3'd1, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 0);
    add(0, R, 3'd1, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 1);
    add(0, R, 3'd7, 1, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 0);
    add(0, R, 3'd7, 1, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 1);
    add(0, LW, 3'd0, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 0);
    add(0, LW, 3'd0, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 1);
    add(0, BQ, 3'd1, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 4'h0, 0);
    add(0, BQ, 3'd1, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 4'h0, 1);
    add(0, I, 3'd1, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 0);
    add(0, I, 3'd1, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 1);
    // reset asserted in MEMWRITE: write masked, back to FETCH
    add(0, SW, 3'd2, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b01, 4'h0, 0);
    add(0, SW, 3'd2, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b01, 4'h0, 0);
    add(0, SW, 3'd2, 0, 0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 4'h0, 0);
    add(1, SW, 3'd2, 0, 0, 4'd5, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b01, 4'h0, 0);
    add(0, SW, 3'd2, 0, 0, 4'd0, 5'b10010, 2'b10, 2'b00, 2'b10, 2'b01, 4'h0, 0);
    add(0, SW, 3'd2, 0, 0, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 2'b01, 4'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst;
      bus.op = vecs[i].op;
      bus.funct3 = vecs[i].f3;
      bus.funct7b5 = vecs[i].f7;
      bus.zero = vecs[i].z;
      #2;
      got = observed();
      n_cmp++;
      if (got !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d op=%b f3=%0d rst=%b: got %b, required %b",
                 i, vecs[i].op, vecs[i].f3, vecs[i].rst, got, vecs[i].exp);
      end else begin
        $display("vec%0d op=%b f3=%0d rst=%b: %b ok", i, vecs[i].op, vecs[i].f3,
                 vecs[i].rst, got);
      end
    end

    // latency from FETCH back to FETCH, FETCH inclusive
    lat_op = '{LW, SW, R, I, JL, BQ, ILL};
    lat_f3 = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    lat_n  = '{5, 4, 4, 4, 4, 3, 2};
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.op = lat_op[k];
      bus.funct3 = lat_f3[k];
      bus.funct7b5 = 1'b0;
      bus.zero = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n = 0;
      do begin
        n++;
        @(posedge clk);
        #1;
      end while (bus.state != 4'd0 && n < 20);
      n_cmp++;
      if (n != lat_n[k]) begin
        n_fail++;
        $display("FAIL latency op=%b: got %0d cycles, required %0d", lat_op[k], n, lat_n[k]);
      end else begin
        $display("latency op=%b: %0d cycles ok", lat_op[k], n);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
